// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: default sizes, op codes and
// FSM state encodings.
package pc_sequencer_pkg;

  localparam int DEF_AW    = 16;
  localparam int DEF_DEPTH = 8;
  localparam int SP_W      = 4;   // width of the return-stack occupancy count

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRA  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_e;

  // Unassigned op codes (6, 7) behave as NEXT.
  function automatic logic [2:0] norm_op(input logic [2:0] code);
    return (code > OP_HALT) ? OP_NEXT : code;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bus between an instruction decoder (master) and the PC
// sequencer (slave).
//
// Handshake: the fetch of address pc completes in the cycle where
// fetch_req=1 and fetch_ready=1. A decoded op is consumed in the cycle where
// op_valid=1 while the sequencer is in EXEC; op_valid carries no meaning in
// any other state. resume is a level sampled only while halted.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int AW = DEF_AW
);

  logic            op_valid;
  logic [2:0]      op_code;
  logic            cond;
  logic [AW-1:0]   target;
  logic            fetch_ready;
  logic            resume;

  logic [AW-1:0]   pc;
  logic            fetch_req;
  logic            halted;
  logic [SP_W-1:0] sp;
  logic            stack_ovf;
  logic            stack_unf;
  seq_state_e      dbg_state;

  modport master (
    output op_valid, op_code, cond, target, fetch_ready, resume,
    input  pc, fetch_req, halted, sp, stack_ovf, stack_unf, dbg_state
  );

  modport slave (
    input  op_valid, op_code, cond, target, fetch_ready, resume,
    output pc, fetch_req, halted, sp, stack_ovf, stack_unf, dbg_state
  );

endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// LIFO return-address stack. One push or one pop per cycle; requests that
// would overflow or underflow are dropped here, the caller flags them.
module ret_stack
  import pc_sequencer_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [AW-1:0]   din,
  output logic [AW-1:0]   dout,
  output logic [SP_W-1:0] count,
  output logic            full,
  output logic            empty
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]   r_mem [DEPTH];
  logic [SP_W-1:0] r_count;
  logic [IW-1:0]   w_wr_idx;
  logic [IW-1:0]   w_top_idx;
  logic            w_do_push;
  logic            w_do_pop;

  assign full      = (r_count == SP_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_wr_idx  = IW'(r_count);
  assign w_top_idx = IW'(r_count - SP_W'(1));
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty && !push;
  assign dout      = r_mem[w_top_idx];

  // Occupancy counter; reset empties the stack without clearing storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + SP_W'(1);
    end else if (w_do_pop) begin
      r_count <= r_count - SP_W'(1);
    end
  end

  // Storage write on push.
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      r_mem[w_wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: FETCH/EXEC/HALT control FSM, next-PC mux,
// return stack and sticky stack-fault flags.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  seq_state_e      r_state;
  seq_state_e      w_next_state;
  logic [AW-1:0]   r_pc;
  logic [AW-1:0]   w_next_pc;
  logic [AW-1:0]   w_pc_inc;
  logic            r_ovf;
  logic            r_unf;
  logic            w_set_ovf;
  logic            w_set_unf;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_stk_dout;
  logic [SP_W-1:0] w_stk_count;
  logic            w_stk_full;
  logic            w_stk_empty;
  logic [2:0]      w_op;

  assign w_pc_inc = r_pc + AW'(1);
  assign w_op     = norm_op(bus.op_code);

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .dout  (w_stk_dout),
    .count (w_stk_count),
    .full  (w_stk_full),
    .empty (w_stk_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, next PC, stack requests and fault detection.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (bus.fetch_ready) begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.op_valid) begin
          w_next_state = ST_FETCH;
          case (w_op)
            OP_JMP: w_next_pc = bus.target;
            OP_BRA: w_next_pc = bus.cond ? bus.target : w_pc_inc;
            OP_CALL: begin
              if (w_stk_full) begin
                w_set_ovf    = 1'b1;
                w_next_state = ST_HALT;
              end else begin
                w_push    = 1'b1;
                w_next_pc = bus.target;
              end
            end
            OP_RET: begin
              if (w_stk_empty) begin
                w_set_unf    = 1'b1;
                w_next_state = ST_HALT;
              end else begin
                w_pop     = 1'b1;
                w_next_pc = w_stk_dout;
              end
            end
            OP_HALT: begin
              w_next_pc    = w_pc_inc;
              w_next_state = ST_HALT;
            end
            default: w_next_pc = w_pc_inc;
          endcase
        end
      end
      ST_HALT: begin
        // A pending stack fault pins the sequencer here until reset.
        if (bus.resume && !r_ovf && !r_unf) begin
          w_next_state = ST_FETCH;
        end
      end
      default: w_next_state = ST_FETCH;
    endcase
  end

  // PC register and sticky fault flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
    end
  end

  assign bus.pc        = r_pc;
  assign bus.fetch_req = (r_state == ST_FETCH);
  assign bus.halted    = (r_state == ST_HALT);
  assign bus.sp        = w_stk_count;
  assign bus.stack_ovf = r_ovf;
  assign bus.stack_unf = r_unf;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the sequencer.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int AW    = 16;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if #(.AW(AW)) bus ();

  pc_sequencer #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- behavioural model ----------------
  // m_mode: 0 = waiting for fetch, 1 = executing, 2 = stopped
  int              m_mode;
  logic [AW-1:0]   m_pc;
  logic [AW-1:0]   exp_q[$];   // return addresses, newest at the back
  logic            m_ovf;
  logic            m_unf;

  task automatic model_step();
    int op;
    if (rst) begin
      m_mode = 0;
      m_pc   = '0;
      exp_q.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (m_mode == 0) begin
      if (bus.fetch_ready) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.op_valid) begin
        op = int'(bus.op_code);
        if (op > 5) op = 0;
        m_mode = 0;
        case (op)
          1: m_pc = bus.target;
          2: m_pc = bus.cond ? bus.target : AW'(m_pc + 1);
          3: begin
            if (exp_q.size() == DEPTH) begin
              m_ovf  = 1'b1;
              m_mode = 2;
            end else begin
              exp_q.push_back(AW'(m_pc + 1));
              m_pc = bus.target;
            end
          end
          4: begin
            if (exp_q.size() == 0) begin
              m_unf  = 1'b1;
              m_mode = 2;
            end else begin
              m_pc = exp_q.pop_back();
            end
          end
          5: begin
            m_pc   = AW'(m_pc + 1);
            m_mode = 2;
          end
          default: m_pc = AW'(m_pc + 1);
        endcase
      end
    end else begin
      if (bus.resume && !m_ovf && !m_unf) m_mode = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},        32'(bus.pc),        32'(m_pc));
    chk({tag, ".sp"},        32'(bus.sp),        32'(exp_q.size()));
    chk({tag, ".fetch_req"}, 32'(bus.fetch_req), 32'(m_mode == 0));
    chk({tag, ".halted"},    32'(bus.halted),    32'(m_mode == 2));
    chk({tag, ".ovf"},       32'(bus.stack_ovf), 32'(m_ovf));
    chk({tag, ".unf"},       32'(bus.stack_unf), 32'(m_unf));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.op_valid    = 1'b0;
    bus.op_code     = OP_NEXT;
    bus.cond        = 1'b0;
    bus.target      = '0;
    bus.fetch_ready = 1'b0;
    bus.resume      = 1'b0;
  endtask

  // One clock: advance the model on the current inputs, then compare.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    set_idle();
    rst = 1'b1;
    cycle(tag);
    rst = 1'b0;
  endtask

  // Complete a fetch, then present one op in EXEC.
  task automatic exec_op(input string tag, input logic [2:0] code,
                         input logic [AW-1:0] tgt, input logic c);
    bus.fetch_ready = 1'b1;
    cycle({tag, ".f"});
    bus.fetch_ready = 1'b0;
    bus.op_valid    = 1'b1;
    bus.op_code     = code;
    bus.target      = tgt;
    bus.cond        = c;
    cycle({tag, ".x"});
    set_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    m_mode = 0;
    m_pc   = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;

    // Reset state and sequential stepping
    do_reset("rst0");
    chk("rst0.fetch_req_first", 32'(bus.fetch_req), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      chk("next.fetch_req", 32'(bus.fetch_req), 32'd1);
      exec_op("next", OP_NEXT, '0, 1'b0);
      chk("next.pc_const", 32'(bus.pc), 32'(i));
    end

    // Branches and wrap-around
    exec_op("jmp10", OP_JMP, 16'h0010, 1'b0);
    exec_op("bra_nt", OP_BRA, 16'h0200, 1'b0);
    chk("bra_nt.pc_const", 32'(bus.pc), 32'h0011);
    exec_op("bra_t", OP_BRA, 16'h0200, 1'b1);
    chk("bra_t.pc_const", 32'(bus.pc), 32'h0200);
    exec_op("jmpffff", OP_JMP, 16'hFFFF, 1'b0);
    exec_op("wrap", OP_NEXT, '0, 1'b0);
    chk("wrap.pc_const", 32'(bus.pc), 32'h0000);

    // Call / return
    exec_op("jmp5", OP_JMP, 16'h0005, 1'b0);
    exec_op("call", OP_CALL, 16'h0100, 1'b0);
    chk("call.pc_const", 32'(bus.pc), 32'h0100);
    chk("call.sp_const", 32'(bus.sp), 32'd1);
    exec_op("ret", OP_RET, '0, 1'b0);
    chk("ret.pc_const", 32'(bus.pc), 32'h0006);
    chk("ret.sp_const", 32'(bus.sp), 32'd0);

    // Unused op codes act as NEXT; op_valid low holds EXEC; op_valid ignored in FETCH
    exec_op("op6", 3'd6, 16'h7777, 1'b1);
    exec_op("op7", 3'd7, 16'h7777, 1'b1);
    bus.op_valid = 1'b1;
    bus.op_code  = OP_JMP;
    bus.target   = 16'h4444;
    for (int i = 0; i < 2; i++) cycle("fetch_ignore_op");
    set_idle();
    bus.fetch_ready = 1'b1;
    cycle("to_exec");
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("exec_hold");
    bus.op_valid = 1'b1;
    bus.op_code  = OP_NEXT;
    cycle("exec_release");
    set_idle();

    // Nested calls to overflow
    do_reset("rst_ovf");
    for (int i = 0; i < 9; i++) begin
      exec_op("ncall", OP_CALL, AW'(16'h0040 + i * 16'h0010), 1'b0);
      if (i == 7) chk("ncall.sp8", 32'(bus.sp), 32'd8);
    end
    chk("ovf.flag", 32'(bus.stack_ovf), 32'd1);
    chk("ovf.halted", 32'(bus.halted), 32'd1);
    chk("ovf.pc_hold", 32'(bus.pc), 32'h00B0);
    bus.resume      = 1'b1;
    bus.fetch_ready = 1'b1;
    bus.op_valid    = 1'b1;
    cycle("ovf_resume_ignored");
    chk("ovf_resume.halted", 32'(bus.halted), 32'd1);
    do_reset("rst_after_ovf");
    chk("rst_after_ovf.ovf", 32'(bus.stack_ovf), 32'd0);

    // Underflow, then HALT op and resume
    exec_op("unf", OP_RET, '0, 1'b0);
    chk("unf.flag", 32'(bus.stack_unf), 32'd1);
    chk("unf.halted", 32'(bus.halted), 32'd1);
    bus.resume = 1'b1;
    cycle("unf_resume_ignored");
    do_reset("rst_after_unf");
    exec_op("jmp20", OP_JMP, 16'h0020, 1'b0);
    exec_op("haltop", OP_HALT, '0, 1'b0);
    chk("haltop.pc_const", 32'(bus.pc), 32'h0021);
    chk("haltop.halted", 32'(bus.halted), 32'd1);
    cycle("halt_wait");
    bus.resume = 1'b1;
    cycle("resume");
    bus.resume = 1'b0;
    chk("resume.fetch_req", 32'(bus.fetch_req), 32'd1);
    chk("resume.pc_const", 32'(bus.pc), 32'h0021);

    // Fetch stall, then reset in the middle of EXEC
    do_reset("rst_stall");
    exec_op("jmp30", OP_JMP, 16'h0030, 1'b0);
    for (int i = 0; i < 5; i++) cycle("stall");
    chk("stall.pc_const", 32'(bus.pc), 32'h0030);
    exec_op("call80", OP_CALL, 16'h0080, 1'b0);
    bus.fetch_ready = 1'b1;
    cycle("pre_rst_fetch");
    bus.fetch_ready = 1'b0;
    bus.op_valid    = 1'b1;
    bus.op_code     = OP_JMP;
    bus.target      = 16'h1234;
    rst             = 1'b1;
    cycle("rst_in_exec");
    rst = 1'b0;
    set_idle();
    chk("rst_in_exec.pc_const", 32'(bus.pc), 32'h0000);
    chk("rst_in_exec.sp_const", 32'(bus.sp), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 59) == 0);
      bus.fetch_ready = ($urandom_range(0, 3) != 0);
      bus.op_valid    = ($urandom_range(0, 2) != 0);
      bus.op_code     = 3'($urandom_range(0, 7));
      bus.cond        = 1'($urandom_range(0, 1));
      bus.target      = AW'($urandom_range(0, 65535));
      bus.resume      = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end
    rst = 1'b0;
    set_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be: AW, default 16, PC/address width; DEPTH, default 8, return-stack entries.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 op_valid  input  1  decoded control op present in EXEC.
REQ-005 op_code  input  3  0=NEXT, 1=JMP, 2=BRA, 3=CALL, 4=RET, 5=HALT; 6-7 treated as NEXT.
REQ-006 cond  input  1  branch condition for BRA.
REQ-007 target  input  AW  absolute jump/branch/call target.
REQ-008 fetch_ready  input  1  instruction memory accepts the current fetch.
REQ-009 resume  input  1  single-cycle restart request while halted.
REQ-010 pc  output  AW  current program counter; registered.
REQ-011 fetch_req  output  1  fetch request for address pc.
REQ-012 halted  output  1  state is HALT.
REQ-013 sp  output  4  return-stack occupancy, 0..DEPTH.
REQ-014 stack_ovf  output  1  sticky: CALL issued with stack full.
REQ-015 stack_unf  output  1  sticky: RET issued with stack empty.

Function
REQ-016 FSM states SHALL be FETCH, EXEC, HALT.
REQ-017 FETCH: fetch_req=1; on fetch_ready=1 go to EXEC next cycle; otherwise hold, pc stable.
REQ-018 EXEC: fetch_req=0; op_valid=0 holds state; op_valid=1 applies op_code, updates pc at the same edge, goes to FETCH unless specified otherwise.
REQ-019 NEXT: pc <= pc+1 modulo 2^AW (0xFFFF -> 0x0000).
REQ-020 JMP: pc <= target.
REQ-021 BRA: pc <= target if cond=1, else pc+1.
REQ-022 CALL, sp<DEPTH: push pc+1 (wrapped), sp <= sp+1, pc <= target.
REQ-023 RET, sp>0: pop top entry into pc, sp <= sp-1.
REQ-024 CALL with sp=DEPTH: no push, pc unchanged, stack_ovf <= 1, go to HALT.
REQ-025 RET with sp=0: pc unchanged, stack_unf <= 1, go to HALT.
REQ-026 HALT op: pc <= pc+1, go to HALT.
REQ-027 HALT: fetch_req=0, halted=1; resume=1 with stack_ovf=stack_unf=0 goes to FETCH, pc unchanged; resume ignored while either fault flag is set.
REQ-028 Fault flags SHALL clear only on rst.
REQ-029 Stack is LIFO; one push or pop per op; push and pop never occur in the same cycle.
REQ-030 Inputs other than rst and resume SHALL be ignored in HALT; op_valid SHALL be ignored in FETCH.

Reset
REQ-031 rst=1 at a rising edge SHALL set state=FETCH, pc=0, sp=0, stack_ovf=0, stack_unf=0, halted=0, from any state, including mid-fetch and mid-EXEC.
REQ-032 rst SHALL take priority over every other input in the same cycle; stack contents need not be cleared.
REQ-033 fetch_req SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-034 The shared package SHALL hold op_code constants, FSM state encodings and default AW/DEPTH.
REQ-035 The return stack SHALL be a sub-module ret_stack (push, pop, din, dout, count, full, empty).
REQ-036 pc_sequencer SHALL contain the FSM, next-PC mux and fault flags.

Verification
REQ-037 Reset, then fetch_ready=1, NEXT x3 -> pc steps 0,1,2,3; fetch_req high in each FETCH.
REQ-038 At pc=0x0010: BRA target=0x0200, cond=0 -> pc=0x0011; then BRA cond=1 -> pc=0x0200; then JMP 0xFFFF, NEXT -> pc=0x0000.
REQ-039 CALL 0x0100 at pc=0x0005 -> pc=0x0100, sp=1; RET -> pc=0x0006, sp=0.
REQ-040 9 nested CALLs -> sp=8 after eighth; ninth sets stack_ovf=1, halted=1, pc unchanged; resume ignored; rst clears all.
REQ-041 RET with sp=0 -> stack_unf=1, halted=1; HALT op at pc=0x0020 -> pc=0x0021, halted=1; resume -> FETCH at 0x0021.
REQ-042 fetch_ready held low 5 cycles -> pc and state unchanged; rst asserted during EXEC with op_valid=1 -> pc=0, sp=0, op not applied.
